// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: FSM encoding, LFSR constants
// and the default array/latency parameters.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_LATENCY    = 2;

  // Wide enough for LATENCY (max 15) plus a 2-bit random extension.
  localparam int CNT_WIDTH = 5;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_responder_lfsr8.sv
// 8-bit Fibonacci LFSR used to jitter the response latency; free-running,
// reseeded whenever the block is reset.
module lfsr8
  import mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value
);

  logic [7:0] lfsr_reg;
  logic       feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], feedback};
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with programmable request-to-response latency.
// Optional feature: define MEM_LAT_RAND_EN to add 0..3 LFSR-driven extra cycles.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic        proto_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0]  lat_load;
  logic                  is_read_reg, is_read_next;
  logic                  err_reg, err_next;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           cap_reg;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  accept, wr_accept, rd_accept;
  logic                  unused_addr_bits;

  // Byte offset and bits above the array aliase away.
  assign word_addr        = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign accept    = (state_reg == IDLE) && (MemRead || MemWrite);
  assign wr_accept = accept && MemWrite;
  assign rd_accept = accept && !MemWrite;

`ifdef MEM_LAT_RAND_EN
  logic [7:0] lfsr_value;
  logic       unused_lfsr_bits;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .rst_n (rst),
    .value (lfsr_value)
  );

  assign lat_load         = CNT_WIDTH'(LATENCY) + CNT_WIDTH'(lfsr_value[1:0]);
  assign unused_lfsr_bits = ^lfsr_value[7:2];
`else
  assign lat_load = CNT_WIDTH'(LATENCY);
`endif

  // Array is never reset; the read word is captured at acceptance so later
  // writes cannot disturb a response that is already in flight.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem[word_addr][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
    if (rd_accept) begin
      cap_reg <= mem[word_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_read_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      is_read_reg <= is_read_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    is_read_next = is_read_reg;
    err_next     = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          is_read_next = !MemWrite;
          if (MemWrite && MemRead) begin
            err_next = 1'b1;
          end
          if (lat_load != '0) begin
            state_next = WAIT;
            cnt_next   = lat_load;
          end else if (!MemWrite) begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        // Leave on the edge where the counter reaches zero.
        if (cnt_reg <= CNT_WIDTH'(1)) begin
          cnt_next   = '0;
          state_next = is_read_reg ? RESP : IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (Read_data_Ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Mem_Req_Ready   = (state_reg == IDLE);
  assign Read_data_Valid = (state_reg == RESP);
  assign Read_data       = Read_data_Valid ? cap_reg : 32'd0;
  assign proto_err       = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a timestamp-based transaction model is
// compared against the LATENCY=2 instance every cycle; a LATENCY=0 instance gets literal checks.
module tb_mem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        mwrite = 1'b0, mread = 1'b0, rready = 1'b1;
  logic        req_ready, rvalid, perr;
  logic [31:0] rdata;

  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  wstrb0 = '0;
  logic        mwrite0 = 1'b0, mread0 = 1'b0, rready0 = 1'b1;
  logic        req_ready0, rvalid0, perr0;
  logic [31:0] rdata0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .Address(addr), .MemWrite(mwrite), .Write_data(wdata),
    .Write_strb(wstrb), .MemRead(mread), .Mem_Req_Ready(req_ready), .Read_data(rdata),
    .Read_data_Valid(rvalid), .Read_data_Ready(rready), .proto_err(perr)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .Address(addr0), .MemWrite(mwrite0), .Write_data(wdata0),
    .Write_strb(wstrb0), .MemRead(mread0), .Mem_Req_Ready(req_ready0), .Read_data(rdata0),
    .Read_data_Valid(rvalid0), .Read_data_Ready(rready0), .proto_err(perr0)
  );

  // Model: a request accepted at edge t makes a read response visible from
  // cycle t+LAT until it is taken, and a write keeps the port busy until t+LAT.
  int unsigned cyc        = 0;
  int unsigned busy_until = 0;
  int unsigned rd_from    = 0;
  bit          rd_pend    = 1'b0;
  bit          err_m      = 1'b0;
  logic [31:0] rd_word    = '0;
  logic [31:0] mem_m [1024];

  logic        exp_ready, exp_valid;
  logic [31:0] exp_data;
  assign exp_ready = !rd_pend && (cyc >= busy_until);
  assign exp_valid = rd_pend && (cyc >= rd_from);
  assign exp_data  = exp_valid ? rd_word : 32'd0;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc        <= 0;
      busy_until <= 0;
      rd_pend    <= 1'b0;
      err_m      <= 1'b0;
    end else begin
      int unsigned t_now;
      t_now = cyc + 1;
      cyc  <= t_now;
      if (exp_valid && rready) begin
        rd_pend    <= 1'b0;
        busy_until <= t_now;
      end
      if (exp_ready && (mwrite || mread)) begin
        if (mwrite) begin
          mem_m[addr[11:2]] <= merge(mem_m[addr[11:2]], wdata, wstrb);
          busy_until        <= t_now + LAT;
          if (mread) err_m <= 1'b1;
        end else begin
          rd_pend <= 1'b1;
          rd_from <= t_now + LAT;
          rd_word <= mem_m[addr[11:2]];
        end
      end
    end
  end

  logic        s_ready, s_valid, s_err, s_ready0, s_valid0;
  logic [31:0] s_data, s_data0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_cycle();
    s_ready  = req_ready;
    s_valid  = rvalid;
    s_data   = rdata;
    s_err    = perr;
    s_ready0 = req_ready0;
    s_valid0 = rvalid0;
    s_data0  = rdata0;
    chk("model_ready", 32'(s_ready), 32'(exp_ready));
    chk("model_valid", 32'(s_valid), 32'(exp_valid));
    chk("model_data", s_data, exp_data);
    chk("model_err", 32'(s_err), 32'(err_m));
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    mwrite = w; mread = r; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    mwrite = 1'b0; mread = 1'b0;
    $display("req  wr=%0b rd=%0b addr=%h data=%h strb=%b", w, r, a, d, s);
  endtask

  task automatic get_resp(output logic [31:0] d, output int lat);
    lat = 0;
    d   = '0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (s_valid) begin
        lat = i;
        d   = s_data;
        break;
      end
    end
    if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
    $display("resp data=%h latency=%0d", d, lat);
  endtask

  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int          lat;
    issue(1'b0, 1'b1, a, 32'd0, 4'd0);
    get_resp(d, lat);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int          lat, n;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    rst = 1'b1;
    tick();

    // Full write then read; write occupancy and read latency
    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (s_ready) begin n = i; break; end
    end
    chk("wr_occupancy", 32'(n), 32'd3);
    issue(1'b0, 1'b1, 32'h10, 32'd0, 4'd0);
    get_resp(d, lat);
    chk("rd_deadbeef", d, 32'hDEADBEEF);
    chk("rd_latency", 32'(lat), 32'd3);

    // Strobed partial write, then all-lanes-off write
    issue(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101);
    read_expect("rd_strobed", 32'h20, 32'h11BB33DD);
    issue(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0000);
    read_expect("rd_strb_zero", 32'h20, 32'h11BB33DD);

    // Aliasing and ignored address bits
    issue(1'b1, 1'b0, 32'h1000, 32'h5, 4'hF);
    read_expect("rd_alias", 32'h0, 32'h5);
    read_expect("rd_high_bits", 32'hFFFFF013, 32'hDEADBEEF);

    // Back-pressure: response held for 5 cycles
    rready = 1'b0;
    issue(1'b0, 1'b1, 32'h10, 32'd0, 4'd0);
    get_resp(d, lat);
    chk("hold_first", d, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data", s_data, 32'hDEADBEEF);
      chk("hold_ready", 32'(s_ready), 32'd0);
    end
    rready = 1'b1;
    tick();
    chk("hold_last_valid", 32'(s_valid), 32'd1);
    tick();
    chk("release_ready", 32'(s_ready), 32'd1);
    chk("release_valid", 32'(s_valid), 32'd0);

    // LATENCY=0 instance
    addr0 = 32'h1000; wdata0 = 32'h5; wstrb0 = 4'hF; mwrite0 = 1'b1;
    tick();
    chk("l0_wr_accept", 32'(s_ready0), 32'd1);
    mwrite0 = 1'b0;
    tick();
    chk("l0_wr_ready_next", 32'(s_ready0), 32'd1);
    addr0 = 32'h0; mread0 = 1'b1;
    tick();
    mread0 = 1'b0;
    $display("req  l0 write 0x1000=5 then read 0x0");
    tick();
    chk("l0_valid_next", 32'(s_valid0), 32'd1);
    chk("l0_data", s_data0, 32'h5);
    tick();
    chk("l0_valid_done", 32'(s_valid0), 32'd0);

    // Simultaneous read and write
    issue(1'b1, 1'b1, 32'h40, 32'h7, 4'hF);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_valid) n++;
    end
    chk("both_no_valid", 32'(n), 32'd0);
    chk("both_err", 32'(s_err), 32'd1);
    read_expect("both_wrote", 32'h40, 32'h7);
    chk("err_sticky", 32'(s_err), 32'd1);

    // Reset during WAIT of a read
    issue(1'b0, 1'b1, 32'h20, 32'd0, 4'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(req_ready), 32'd1);
    chk("rst_wait_valid", 32'(rvalid), 32'd0);
    chk("rst_wait_data", rdata, 32'd0);
    tick(); tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_valid) n++;
    end
    chk("no_resp_after_rst", 32'(n), 32'd0);
    chk("err_cleared", 32'(s_err), 32'd0);
    read_expect("mem_persists", 32'h20, 32'h11BB33DD);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of the internal array (1024 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port Address, input, 32 bits: byte address of the request.
REQ-006 SHALL have port MemWrite, input, 1 bit: write request valid.
REQ-007 SHALL have port Write_data, input, 32 bits: write data.
REQ-008 SHALL have port Write_strb, input, 4 bits: byte-lane enables; bit i enables Write_data[8i+7:8i].
REQ-009 SHALL have port MemRead, input, 1 bit: read request valid.
REQ-010 SHALL have port Mem_Req_Ready, output, 1 bit: request accepted this cycle when high together with MemRead or MemWrite.
REQ-011 SHALL have port Read_data, output, 32 bits: read response data.
REQ-012 SHALL have port Read_data_Valid, output, 1 bit: response valid.
REQ-013 SHALL have port Read_data_Ready, input, 1 bit: initiator accepts the response.
REQ-014 SHALL have port proto_err, output, 1 bit: sticky flag, set when MemRead and MemWrite are both high at acceptance.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; Mem_Req_Ready = 1 only in IDLE.
REQ-016 IDLE: on MemWrite & Mem_Req_Ready, SHALL commit the strobed bytes to word Address[ADDR_WIDTH+1:2] at that edge, then go to WAIT if latency>0, else stay in IDLE; no response is generated.
REQ-017 IDLE: on MemRead & Mem_Req_Ready (MemWrite low), SHALL capture the array word at the request address, then go to WAIT if latency>0, else to RESP.
REQ-018 WAIT: SHALL count down the latency value loaded at acceptance; on reaching zero, go to RESP for a read and to IDLE for a write.
REQ-019 RESP: Read_data_Valid = 1 and Read_data SHALL stay stable until the cycle in which Read_data_Ready = 1; that edge returns to IDLE.
REQ-020 Read latency, acceptance edge to first Read_data_Valid cycle, SHALL be latency+1 cycles; write occupancy SHALL be latency+1 cycles before Mem_Req_Ready rises again.
REQ-021 Address[31:ADDR_WIDTH+2] and Address[1:0] SHALL be ignored; addresses wrap and alias modulo the array size.
REQ-022 MemRead and MemWrite both high at acceptance: SHALL be handled as a write only, set proto_err, and produce no read response.
REQ-023 A read accepted after a write SHALL return the post-write data (read-after-write coherent).
REQ-024 Write_strb = 4'b0000 on a write SHALL leave the array unchanged but still follow the write timing.
REQ-025 Read_data SHALL be 0 whenever Read_data_Valid = 0.

Reset
REQ-026 On rst low, SHALL enter IDLE asynchronously: Mem_Req_Ready = 1, Read_data_Valid = 0, Read_data = 0, proto_err = 0, latency counter = 0.
REQ-027 Reset mid-WAIT or mid-RESP SHALL drop the pending response; a write already committed at its acceptance edge SHALL persist.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro MEM_LAT_RAND_EN defined, the loaded latency SHALL be LATENCY + lfsr[1:0]; the 8-bit LFSR (x^8+x^6+x^5+x^4+1) is seeded 8'hA5 on reset and advances every cycle.
REQ-030 Without MEM_LAT_RAND_EN, the loaded latency SHALL be exactly LATENCY, and no LFSR logic is present.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding, the LFSR seed and taps, and the LATENCY and ADDR_WIDTH defaults.
REQ-032 The LFSR SHALL be a separate sub-module lfsr8, instantiated only under MEM_LAT_RAND_EN.

Verification
REQ-033 Write 32'hDEADBEEF with strb 4'hF to 0x10, then read 0x10 -> Read_data = 32'hDEADBEEF, Valid rises 3 cycles after read acceptance (LATENCY=2).
REQ-034 Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with strb 4'b0101 to 0x20; read 0x20 -> 32'h11BB33DD.
REQ-035 Read held with Read_data_Ready low for 5 cycles -> Valid and Read_data stable for all 5 cycles; Mem_Req_Ready = 0 throughout; IDLE on the cycle after Ready = 1.
REQ-036 With ADDR_WIDTH=10, write 32'h5 to 0x1000, then read 0x0 -> 32'h5 (alias); LATENCY=0 read -> Valid on the cycle after acceptance.
REQ-037 MemRead and MemWrite both high (Write_data 32'h7) -> proto_err = 1 and stays 1; no Read_data_Valid; a later read returns 32'h7.
REQ-038 rst low during WAIT of a read -> immediately Mem_Req_Ready = 1 and Read_data_Valid = 0; no response after rst is released.
